// File: rtl/inst_rom_loader_if.sv
// -----------------------------------------------------------------------------
// inst_rom_loader_if
// Purpose : groups the core fetch port and the byte-serial loader stream of
//           inst_rom_loader into one bundle.
// Signals : rom_ce_i/rom_addr_i/rom_data_o  - instruction fetch port
//           ld_start_i/ld_len_i             - load request and word count
//           ld_valid_i/ld_byte_i/ld_ready_o - byte stream handshake
//           ld_done_o/cpu_hold_o/oob_o      - status back to the SoC
// Modports: master (core / loader source side), slave (the ROM loader).
// -----------------------------------------------------------------------------
interface inst_rom_loader_if #(
  parameter int ADDR_W = 10
);
  logic              rom_ce_i;
  logic [31:0]       rom_addr_i;
  logic [31:0]       rom_data_o;
  logic              ld_start_i;
  logic [ADDR_W:0]   ld_len_i;
  logic              ld_valid_i;
  logic [7:0]        ld_byte_i;
  logic              ld_ready_o;
  logic              ld_done_o;
  logic              cpu_hold_o;
  logic              oob_o;

  modport master (
    output rom_ce_i, rom_addr_i, ld_start_i, ld_len_i, ld_valid_i, ld_byte_i,
    input  rom_data_o, ld_ready_o, ld_done_o, cpu_hold_o, oob_o
  );

  modport slave (
    input  rom_ce_i, rom_addr_i, ld_start_i, ld_len_i, ld_valid_i, ld_byte_i,
    output rom_data_o, ld_ready_o, ld_done_o, cpu_hold_o, oob_o
  );
endinterface

// File: rtl/inst_rom_loader.sv
// -----------------------------------------------------------------------------
// inst_rom_loader
// Purpose : instruction store answering the core's fetch port combinationally,
//           plus a byte-serial loader that fills the store big-endian while
//           holding the core in reset.
// Ports   : clk  - system clock (rising edge)
//           rst  - asynchronous active-high reset
//           bus  - inst_rom_loader_if.slave (fetch port + loader stream/status)
// -----------------------------------------------------------------------------
module inst_rom_loader #(
  parameter int ADDR_W = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  inst_rom_loader_if.slave       bus
);
  localparam int              DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LEN_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic [1:0]          bcnt_q, bcnt_d;
  logic [23:0]         shreg_q, shreg_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic                ld_ready_q, ld_ready_d;
  logic                ld_done_q, ld_done_d;
  logic                cpu_hold_q, cpu_hold_d;
  logic                oob_q, oob_d;

  logic [31:0]         mem_q [DEPTH];
  logic                mem_we_s;
  logic [31:0]         mem_wdata_s;
  logic                addr_legal_s;
  logic                rd_en_s;
  logic                byte_acc_s;

  // Word-aligned and inside the store; upper address bits must all be zero.
  assign addr_legal_s = (bus.rom_addr_i[1:0] == 2'b00) &&
                        (bus.rom_addr_i[31:ADDR_W+2] == {(30-ADDR_W){1'b0}});
  // A fetch is only serviced while the core is out of hold, so reads never
  // collide with loader writes.
  assign rd_en_s      = bus.rom_ce_i & ~cpu_hold_q;
  assign byte_acc_s   = bus.ld_valid_i & ld_ready_q;

  // Combinational fetch data: store word for legal enabled fetches, else zero.
  always_comb begin
    bus.rom_data_o = 32'h0000_0000;
    if (rd_en_s && addr_legal_s) begin
      bus.rom_data_o = mem_q[bus.rom_addr_i[ADDR_W+1:2]];
    end else begin
      bus.rom_data_o = 32'h0000_0000;
    end
  end

  // Loader FSM next state, datapath next values and registered-output decode.
  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    bcnt_d      = bcnt_q;
    shreg_d     = shreg_q;
    len_d       = len_q;
    oob_d       = oob_q;
    mem_we_s    = 1'b0;
    mem_wdata_s = {shreg_q, bus.ld_byte_i};

    if (rd_en_s && !addr_legal_s) begin
      oob_d = 1'b1;
    end else begin
      oob_d = oob_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.ld_start_i) begin
          // An accepted start clears the sticky flag even if the same cycle
          // also carries an illegal fetch.
          oob_d  = 1'b0;
          wptr_d = {ADDR_W{1'b0}};
          bcnt_d = 2'd0;
          if (bus.ld_len_i != {(ADDR_W+1){1'b0}}) begin
            state_d = ST_LOAD;
            len_d   = (bus.ld_len_i > DEPTH_LEN) ? DEPTH_LEN : bus.ld_len_i;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (byte_acc_s) begin
          shreg_d = {shreg_q[15:0], bus.ld_byte_i};
          bcnt_d  = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            // Fourth byte completes the word; earliest byte lands in the MSB.
            mem_we_s = 1'b1;
            wptr_d   = wptr_q + PTR_ONE;
            if ({1'b0, wptr_q} == (len_q - LEN_ONE)) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_LOAD;
            end
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered copies of what the next state implies.
    ld_ready_d = (state_d == ST_LOAD);
    ld_done_d  = (state_d == ST_DONE);
    cpu_hold_d = (state_d != ST_IDLE);
  end

  // State and control registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wptr_q     <= {ADDR_W{1'b0}};
      bcnt_q     <= 2'd0;
      shreg_q    <= 24'h00_0000;
      len_q      <= {(ADDR_W+1){1'b0}};
      ld_ready_q <= 1'b0;
      ld_done_q  <= 1'b0;
      cpu_hold_q <= 1'b0;
      oob_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      bcnt_q     <= bcnt_d;
      shreg_q    <= shreg_d;
      len_q      <= len_d;
      ld_ready_q <= ld_ready_d;
      ld_done_q  <= ld_done_d;
      cpu_hold_q <= cpu_hold_d;
      oob_q      <= oob_d;
    end
  end

  // Word store write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[wptr_q] <= mem_wdata_s;
    end
  end

  assign bus.ld_ready_o = ld_ready_q;
  assign bus.ld_done_o  = ld_done_q;
  assign bus.cpu_hold_o = cpu_hold_q;
  assign bus.oob_o      = oob_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// -----------------------------------------------------------------------------
// tb_inst_rom_loader
// Directed bench for inst_rom_loader: reset values, big-endian loading,
// backpressure, ignored restart, zero/oversized lengths, illegal fetches and
// reset in the middle of a load.
// -----------------------------------------------------------------------------
module tb_inst_rom_loader;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  inst_rom_loader_if #(.ADDR_W(AW)) bus ();

  inst_rom_loader #(.ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [AW:0] len);
    bus.ld_start_i = 1'b1;
    bus.ld_len_i   = len;
    tick();
    bus.ld_start_i = 1'b0;
  endtask

  // Present one byte; optional idle cycle first. Returns after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    n = 0;
    if (gap) begin
      bus.ld_valid_i = 1'b0;
      tick();
    end
    bus.ld_valid_i = 1'b1;
    bus.ld_byte_i  = b;
    while (!bus.ld_ready_o && n < 20) begin
      tick();
      n++;
    end
    if (!bus.ld_ready_o) begin
      check_eq("ready_timeout", {31'd0, bus.ld_ready_o}, 32'd1);
    end
    tick();
    bus.ld_valid_i = 1'b0;
  endtask

  task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    bus.rom_ce_i   = 1'b1;
    bus.rom_addr_i = addr;
    #1;
    check_eq(tag, bus.rom_data_o, exp);
    bus.rom_ce_i   = 1'b0;
  endtask

  logic [7:0] main_bytes [8];
  logic [7:0] alt_bytes  [8];
  int         done_cnt;
  int         done_idx;

  initial begin
    checks   = 0;
    failures = 0;
    main_bytes = '{8'h34, 8'h02, 8'h00, 8'h05, 8'h3C, 8'h01, 8'h12, 8'h34};
    alt_bytes  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    rst            = 1'b0;
    bus.rom_ce_i   = 1'b0;
    bus.rom_addr_i = 32'h0;
    bus.ld_start_i = 1'b0;
    bus.ld_len_i   = '0;
    bus.ld_valid_i = 1'b0;
    bus.ld_byte_i  = 8'h00;

    // Reset asserted asynchronously mid-cycle.
    #3 rst = 1'b1;
    #1;
    check_eq("rst_ready", {31'd0, bus.ld_ready_o}, 32'd0);
    check_eq("rst_done",  {31'd0, bus.ld_done_o},  32'd0);
    check_eq("rst_hold",  {31'd0, bus.cpu_hold_o}, 32'd0);
    check_eq("rst_oob",   {31'd0, bus.oob_o},      32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_eq("post_rst_hold", {31'd0, bus.cpu_hold_o}, 32'd0);
    check_eq("post_rst_ready", {31'd0, bus.ld_ready_o}, 32'd0);

    // Main 2-word load, back-to-back bytes.
    start_load(11'd2);
    check_eq("main_hold_on", {31'd0, bus.cpu_hold_o}, 32'd1);
    check_eq("main_ready_on", {31'd0, bus.ld_ready_o}, 32'd1);
    fetch("main_read_in_hold", 32'h0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      send_byte(main_bytes[i], 1'b0);
      if (i == 6) check_eq("main_no_early_done", {31'd0, bus.ld_done_o}, 32'd0);
    end
    check_eq("main_done",     {31'd0, bus.ld_done_o},  32'd1);
    check_eq("main_done_hold", {31'd0, bus.cpu_hold_o}, 32'd1);
    check_eq("main_done_ready", {31'd0, bus.ld_ready_o}, 32'd0);
    tick();
    check_eq("main_done_clr", {31'd0, bus.ld_done_o},  32'd0);
    check_eq("main_hold_off", {31'd0, bus.cpu_hold_o}, 32'd0);
    fetch("main_w0", 32'h0, 32'h3402_0005);
    fetch("main_w1", 32'h4, 32'h3C01_1234);
    fetch("ce_off", 32'h0, 32'h3402_0005);
    bus.rom_addr_i = 32'h0;
    #1;
    check_eq("ce_low_zero", bus.rom_data_o, 32'h0);
    check_eq("main_oob", {31'd0, bus.oob_o}, 32'd0);

    // Overwrite with a different image.
    tick();
    start_load(11'd2);
    for (int i = 0; i < 8; i++) send_byte(alt_bytes[i], 1'b0);
    tick();
    fetch("alt_w0", 32'h0, 32'h1122_3344);
    fetch("alt_w1", 32'h4, 32'h5566_7788);

    // Main stream again with a gap before every byte and a stray start pulse.
    tick();
    start_load(11'd2);
    for (int i = 0; i < 8; i++) begin
      send_byte(main_bytes[i], 1'b1);
      if (i == 4) begin
        bus.ld_start_i = 1'b1;
        bus.ld_len_i   = 11'd1;
        tick();
        bus.ld_start_i = 1'b0;
        check_eq("gap_restart_ignored", {31'd0, bus.ld_ready_o}, 32'd1);
        fetch("gap_read_in_hold", 32'h0, 32'h0);
      end
    end
    check_eq("gap_done", {31'd0, bus.ld_done_o}, 32'd1);
    tick();
    fetch("gap_w0", 32'h0, 32'h3402_0005);
    fetch("gap_w1", 32'h4, 32'h3C01_1234);

    // Zero length: done next cycle, store untouched.
    tick();
    start_load(11'd0);
    check_eq("len0_done",  {31'd0, bus.ld_done_o},  32'd1);
    check_eq("len0_ready", {31'd0, bus.ld_ready_o}, 32'd0);
    tick();
    check_eq("len0_done_clr", {31'd0, bus.ld_done_o},  32'd0);
    check_eq("len0_hold_off", {31'd0, bus.cpu_hold_o}, 32'd0);
    fetch("len0_w0", 32'h0, 32'h3402_0005);
    fetch("len0_w1", 32'h4, 32'h3C01_1234);

    // Illegal fetches: misaligned, then just past the store.
    tick();
    bus.rom_ce_i   = 1'b1;
    bus.rom_addr_i = 32'h0000_0002;
    #1;
    check_eq("misalign_data", bus.rom_data_o, 32'h0);
    tick();
    check_eq("misalign_oob", {31'd0, bus.oob_o}, 32'd1);
    bus.rom_addr_i = 32'h0;
    tick();
    check_eq("oob_sticky", {31'd0, bus.oob_o}, 32'd1);
    check_eq("legal_while_oob", bus.rom_data_o, 32'h3402_0005);
    bus.rom_ce_i = 1'b0;
    start_load(11'd0);
    check_eq("oob_clr1", {31'd0, bus.oob_o}, 32'd0);
    tick();
    bus.rom_ce_i   = 1'b1;
    bus.rom_addr_i = DEPTH * 4;
    #1;
    check_eq("past_end_data", bus.rom_data_o, 32'h0);
    tick();
    bus.rom_ce_i = 1'b0;
    tick();
    check_eq("past_end_oob", {31'd0, bus.oob_o}, 32'd1);
    start_load(11'd0);
    check_eq("oob_clr2", {31'd0, bus.oob_o}, 32'd0);
    tick();

    // Oversized length: exactly DEPTH words, then DONE.
    start_load(11'(DEPTH + 5));
    done_cnt = 0;
    done_idx = -1;
    for (int i = 0; i < DEPTH * 4; i++) begin
      send_byte(8'(i), 1'b0);
      if (bus.ld_done_o) begin
        done_cnt++;
        done_idx = i;
      end
    end
    check_eq("big_done_cnt", done_cnt, 32'd1);
    check_eq("big_done_idx", done_idx, DEPTH * 4 - 1);
    bus.ld_valid_i = 1'b1;
    bus.ld_byte_i  = 8'hEE;
    tick();
    tick();
    tick();
    check_eq("big_no_more_ready", {31'd0, bus.ld_ready_o}, 32'd0);
    check_eq("big_hold_off",      {31'd0, bus.cpu_hold_o}, 32'd0);
    bus.ld_valid_i = 1'b0;
    fetch("big_w0",    32'h0,   32'h0001_0203);
    fetch("big_w5",    32'h14,  32'h1415_1617);
    fetch("big_wlast", 32'hFFC, 32'hFCFD_FEFF);

    // Reset after five bytes: word 0 kept, word 1 untouched, hold drops at once.
    tick();
    start_load(11'd2);
    send_byte(8'hA1, 1'b0);
    send_byte(8'hA2, 1'b0);
    send_byte(8'hA3, 1'b0);
    send_byte(8'hA4, 1'b0);
    send_byte(8'hB1, 1'b0);
    #3 rst = 1'b1;
    #1;
    check_eq("midrst_hold",  {31'd0, bus.cpu_hold_o}, 32'd0);
    check_eq("midrst_ready", {31'd0, bus.ld_ready_o}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    fetch("midrst_w0", 32'h0, 32'hA1A2_A3A4);
    fetch("midrst_w1", 32'h4, 32'h0405_0607);

    // Fresh one-word load after the abort starts from a clean byte count.
    tick();
    start_load(11'd1);
    send_byte(8'hC0, 1'b0);
    send_byte(8'hC1, 1'b0);
    send_byte(8'hC2, 1'b0);
    send_byte(8'hC3, 1'b0);
    check_eq("fresh_done", {31'd0, bus.ld_done_o}, 32'd1);
    tick();
    fetch("fresh_w0", 32'h0, 32'hC0C1_C2C3);
    fetch("fresh_w1", 32'h4, 32'h0405_0607);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
